// File: rtl/thor2022_ictag_vlru_pkg.sv
// Shared types and default geometry for the Thor2022 I-cache tag store.
package thor2022_ictag_vlru_pkg;

  localparam int ICACHE_LINES = 128;
  localparam int ICACHE_WAYS  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } ictag_state_t;

endpackage

// File: rtl/thor2022_ictag_vlru_wayram.sv
// One way of the tag store: distributed-RAM tags plus a valid vector.
// Synchronous write and clear, asynchronous multi-port read.
module thor2022_ictag_wayram #(
  parameter int LINES = 128,
  parameter int SETB  = 7,
  parameter int TAGW  = 19,
  parameter int NRD   = 3
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [SETB-1:0]           wadr_i,
  input  logic [TAGW-1:0]           wtag_i,
  input  logic                      clr_i,
  input  logic [SETB-1:0]           cadr_i,
  input  logic [NRD-1:0][SETB-1:0]  radr_i,
  output logic [NRD-1:0][TAGW-1:0]  rtag_o,
  output logic [NRD-1:0]            rvld_o
);

  logic [TAGW-1:0]  tag_q [LINES];
  logic [LINES-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (we_i) tag_q[wadr_i] <= wtag_i;
  end

  // Clear is ordered after set so a same-line write and clear leaves the line invalid.
  always_ff @(posedge clk) begin
    if (we_i)  vld_q[wadr_i] <= 1'b1;
    if (clr_i) vld_q[cadr_i] <= 1'b0;
  end

  always_comb begin
    for (int r = 0; r < NRD; r++) begin
      rtag_o[r] = tag_q[radr_i[r]];
      rvld_o[r] = vld_q[radr_i[r]];
    end
  end

endmodule

// File: rtl/thor2022_ictag_vlru.sv
// I-cache tag store: registered lookup, round-robin fill, line invalidate and
// a sequenced whole-cache sweep that also runs out of reset.
module thor2022_ictag_vlru
  import thor2022_ictag_vlru_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WAYS  = ICACHE_WAYS,
  parameter int AWID  = 32,
  parameter int LOBIT = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AWID-1:0]          ip,
  output logic                     hit,
  output logic [$clog2(WAYS)-1:0]  hit_way,
  input  logic                     wr,
  input  logic [AWID-1:0]          wr_adr,
  output logic [$clog2(WAYS)-1:0]  fill_way,
  input  logic                     inv_line,
  input  logic [AWID-1:0]          inv_adr,
  input  logic                     inv_all,
  output logic                     busy
);

  localparam int SETB   = $clog2(LINES);
  localparam int WAYB   = $clog2(WAYS);
  localparam int TAGLO  = LOBIT + SETB;
  localparam int TAGW   = AWID - TAGLO;
  localparam int NRD    = 3;
  localparam int RD_LK  = 0;
  localparam int RD_WR  = 1;
  localparam int RD_INV = 2;

  ictag_state_t    state_q;
  logic [SETB-1:0] cnt_q;
  logic            sweeping;

  logic [SETB-1:0] ip_set, wr_set, inv_set, clr_adr;
  logic [TAGW-1:0] ip_tag, wr_tag, inv_tag;
  logic            unused_lsb;

  logic [NRD-1:0][SETB-1:0] rd_adr;
  logic [NRD-1:0][TAGW-1:0] rd_tag [WAYS];
  logic [NRD-1:0]           rd_vld [WAYS];

  logic [WAYS-1:0] lk_match, wr_match, inv_match;
  logic [WAYS-1:0] way_we, way_clr;
  logic [WAYB-1:0] lk_way, wr_way, inv_way, fill_tgt;
  logic            wr_hit, inv_hit, fill_en, inv_en;

  logic [WAYB-1:0] rr_q [LINES];
  logic            hit_q;
  logic [WAYB-1:0] hit_way_q, fill_way_q;

  assign sweeping = (state_q == SWEEP);

  assign ip_set  = ip[TAGLO-1:LOBIT];
  assign ip_tag  = ip[AWID-1:TAGLO];
  assign wr_set  = wr_adr[TAGLO-1:LOBIT];
  assign wr_tag  = wr_adr[AWID-1:TAGLO];
  assign inv_set = inv_adr[TAGLO-1:LOBIT];
  assign inv_tag = inv_adr[AWID-1:TAGLO];
  assign unused_lsb = ^{ip[LOBIT-1:0], wr_adr[LOBIT-1:0], inv_adr[LOBIT-1:0]};

  assign rd_adr[RD_LK]  = ip_set;
  assign rd_adr[RD_WR]  = wr_set;
  assign rd_adr[RD_INV] = inv_set;

  assign fill_en = wr & ~rst & ~sweeping;
  assign inv_en  = inv_line & ~rst & ~sweeping;
  assign clr_adr = sweeping ? cnt_q : inv_set;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    thor2022_ictag_wayram #(
      .LINES (LINES),
      .SETB  (SETB),
      .TAGW  (TAGW),
      .NRD   (NRD)
    ) u_ram (
      .clk    (clk),
      .we_i   (way_we[w]),
      .wadr_i (wr_set),
      .wtag_i (wr_tag),
      .clr_i  (way_clr[w]),
      .cadr_i (clr_adr),
      .radr_i (rd_adr),
      .rtag_o (rd_tag[w]),
      .rvld_o (rd_vld[w])
    );

    assign lk_match[w]  = rd_vld[w][RD_LK]  && (rd_tag[w][RD_LK]  == ip_tag);
    assign wr_match[w]  = rd_vld[w][RD_WR]  && (rd_tag[w][RD_WR]  == wr_tag);
    assign inv_match[w] = rd_vld[w][RD_INV] && (rd_tag[w][RD_INV] == inv_tag);
  end

  // Descending scan so the lowest matching way is the one that sticks.
  always_comb begin
    lk_way  = '0;
    wr_way  = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_match[w])  lk_way  = WAYB'(w);
      if (wr_match[w])  wr_way  = WAYB'(w);
      if (inv_match[w]) inv_way = WAYB'(w);
    end
  end

  assign wr_hit   = |wr_match;
  assign inv_hit  = |inv_match;
  assign fill_tgt = wr_hit ? wr_way : rr_q[wr_set];

  always_comb begin
    way_we  = '0;
    way_clr = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_we[w]  = fill_en && (fill_tgt == WAYB'(w));
      way_clr[w] = sweeping || (inv_en && inv_hit && (inv_way == WAYB'(w)));
    end
  end

  // Refills of a resident tag keep the rotation where it is.
  always_ff @(posedge clk) begin
    if (sweeping) begin
      rr_q[cnt_q] <= '0;
    end else if (fill_en && !wr_hit) begin
      rr_q[wr_set] <= rr_q[wr_set] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inv_all) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          if (inv_all) begin
            cnt_q <= '0;
          end else begin
            if (cnt_q == SETB'(LINES - 1)) state_q <= IDLE;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      hit_way_q  <= '0;
      fill_way_q <= '0;
    end else begin
      hit_q     <= ~sweeping & (|lk_match);
      hit_way_q <= sweeping ? '0 : lk_way;
      if (fill_en) fill_way_q <= fill_tgt;
    end
  end

  assign hit      = hit_q;
  assign hit_way  = hit_way_q;
  assign fill_way = fill_way_q;
  assign busy     = sweeping;

endmodule
